irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Multi-source interrupt controller placed directly upstream of the special-register block. It collects external interrupt lines and latches rising edges into a pending register. It applies a software-writable mask, selects the highest-priority pending source and drives the single `irq_in` request line into the special registers. It also tracks the request/acknowledge/service cycle against the core's `irq_en` state and exposes mask, pending and current-source id on the special-register bus.

## Interface
- `NSRC`, default 8: number of interrupt sources, 1..16.
- `SR_MASK`, default 5: `sr_sel` value of the mask register.
- `SR_PEND`, default 6: `sr_sel` value of the pending register.
- `SR_SRC`, default 7: `sr_sel` value of the current-source register, read-only.

Ports:
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `irq_src` in NSRC: external interrupt lines; rising-edge triggered.
- `sr_ie` in 1: special-register write enable.
- `sr_sel` in 16: special-register select.
- `sr_in` in 16: special-register write data.
- `sr_out` out 16: combinational read data, driven as follows:
  - `SR_MASK`: mask, zero-extended.
  - `SR_PEND`: pending, zero-extended.
  - `SR_SRC`: current source id in bits [3:0].
  - any other select: 0.
- `irq_en` in 1: interrupt-enable state from the special registers.
- `irq_ack` in 1: one-cycle pulse from the PC module when it takes the jump to vector 0x1.
- `irq_out` out 1: registered request, connected to the special registers' `irq_in`.

## Operation
- Edge detect: `prev_src` register holds the sampled `irq_src`. A pending bit i sets on an edge where `irq_src[i]` is 1 and `prev_src[i]` is 0. Level-high sources do not retrigger.
- Mask write (`sr_ie` and `sr_sel == SR_MASK`): `mask <= sr_in[NSRC-1:0]`.
- Pending write (`sr_ie` and `sr_sel == SR_PEND`): write-1-to-clear. A new edge on the same bit in the same cycle wins, so the bit stays set.
- Writes to `SR_SRC` and to unlisted selects are ignored.
- Priority: lowest index of `pending & mask` wins.
- FSM states:
  - IDLE: if `irq_en` and `pending & mask` is nonzero, latch the winner into `cur_src`, set `irq_out`, go to REQ.
  - REQ: `irq_out` held at 1. On `irq_ack`, clear `irq_out` and `pending[cur_src]`, go to SERVICE. While in REQ, `cur_src` is frozen even if a higher-priority source arrives.
  - SERVICE: handler running. Wait for `irq_en` to be seen low, then high again (iret or software re-enable), then go to IDLE. `cur_src` is held for handler readout.
- If the selected source becomes masked or is W1C-cleared while in REQ, the request is still delivered. The handler sees `cur_src` and its pending bit already cleared.
- The `irq_ack` pending clear and a new edge on the same source in the same cycle leave the bit set.
- `irq_ack` in IDLE or SERVICE is ignored.

## Timing
- Reset: `irq_out`=0, `mask`=0, `pending`=0, `prev_src`=0, `cur_src`=0, state IDLE. Reset applies immediately, including mid-REQ.
- Edge to pending: pending bit visible after the first rising edge that samples the line high (this is `clk` edge N).
- Pending to request: `irq_out`=1 after edge N+1, provided `irq_en` and mask allow it.
- Ack to release: `irq_out` drops after the edge that samples `irq_ack`. The special registers then see `irq_in` fall and clear `irq_en`.
- `sr_out` is purely combinational from register state and `sr_sel`. Write effects are visible after the writing edge.
- Minimum spacing between two serviced interrupts: 2 cycles after `irq_en` returns high.

## Configuration
- `IRQ_SYNC_EN` defined: `irq_src` passes through a 2-flop synchronizer before edge detect. Edge-to-pending latency becomes 3 edges; all other timing is unchanged. Synchronizer flops reset to 0.
- `IRQ_SYNC_EN` undefined: `irq_src` is used directly. Sources must be synchronous to `clk`.

## Test plan
- Basic request: mask=0x01, `irq_en`=1, pulse `irq_src[0]`. Expect:
  - `pending`=0x01 after edge N;
  - `irq_out`=1 after N+1;
  - on `irq_ack`, `irq_out`=0 and pending=0;
  - `SR_SRC` reads 0.
- Priority and freeze: raise sources 5 and 2 on the same cycle, mask=0xFF. Expect `cur_src`=2 with pending still 0x20 after ack. Raise source 0 during REQ and expect `cur_src` to stay 2.
- Masking: source 3 pending with mask=0 gives no `irq_out`. Write mask=0x08 and expect `irq_out`=1 two edges later.
- SERVICE gating: after ack, keep `irq_en`=0 with source 1 pending. Expect no request. Raise `irq_en` and expect `irq_out`=1 within 2 cycles.
- W1C collision: write 0x04 to `SR_PEND` in the same cycle as a new edge on source 2. Expect `pending[2]`=1.
- Reset: assert `rst_n`=0 during REQ. Expect `irq_out`=0, mask=0, pending=0 asynchronously. With `IRQ_SYNC_EN`, re-run the basic request and expect pending after 3 edges.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Special-register bus between the core's special-register block and irq_ctrl.
// The master drives select/write data; the slave returns combinational read data.
interface irq_ctrl_if;
    logic        sr_ie;
    logic [15:0] sr_sel;
    logic [15:0] sr_in;
    logic [15:0] sr_out;

    modport master (output sr_ie, output sr_sel, output sr_in, input sr_out);
    modport slave  (input sr_ie, input sr_sel, input sr_in, output sr_out);
endinterface

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: edge-latched pending bits, mask, fixed priority,
// single registered request to the special registers. Define IRQ_SYNC_EN to add a 2-flop input synchronizer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no request outstanding; waiting for irq_en and a masked-in pending source
// S_REQ     | irq_out high, cur_src frozen, waiting for irq_ack
// S_SVC     | handler running; waiting for irq_en to be seen low
// S_SVC_LOW | irq_en seen low; waiting for it to return high before arbitrating again
module irq_ctrl #(
    parameter int NSRC    = 8,
    parameter int SR_MASK = 5,
    parameter int SR_PEND = 6,
    parameter int SR_SRC  = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_src,
    input  logic            irq_en,
    input  logic            irq_ack,
    output logic            irq_out,
    irq_ctrl_if.slave       sr
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SVC     = 2'd2,
        S_SVC_LOW = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [NSRC-1:0] src_s;
    logic [NSRC-1:0] prev_src;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] pending_n;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] pend_clr;
    logic [3:0]      winner;
    logic [3:0]      cur_src;
    logic [3:0]      cur_src_n;
    logic            irq_out_n;
    logic            ack_take;
    logic            mask_we;
    logic            pend_we;

`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] sync_1;
    logic [NSRC-1:0] sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= irq_src;
            sync_2 <= sync_1;
        end
    end

    assign src_s = sync_2;
`else
    assign src_s = irq_src;
`endif

    assign mask_we = sr.sr_ie && (sr.sr_sel == 16'(SR_MASK));
    assign pend_we = sr.sr_ie && (sr.sr_sel == 16'(SR_PEND));
    assign active  = pending & mask;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                winner = 4'(i);
            end
        end
    end

    always_comb begin
        state_n   = state;
        irq_out_n = irq_out;
        cur_src_n = cur_src;
        ack_take  = 1'b0;
        case (state)
            S_IDLE: begin
                if (irq_en && (active != '0)) begin
                    cur_src_n = winner;
                    irq_out_n = 1'b1;
                    state_n   = S_REQ;
                end
            end
            S_REQ: begin
                irq_out_n = 1'b1;
                if (irq_ack) begin
                    irq_out_n = 1'b0;
                    ack_take  = 1'b1;
                    state_n   = S_SVC;
                end
            end
            S_SVC: begin
                if (!irq_en) begin
                    state_n = S_SVC_LOW;
                end
            end
            S_SVC_LOW: begin
                if (irq_en) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n   = S_IDLE;
                irq_out_n = 1'b0;
            end
        endcase
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = ack_take && (4'(i) == cur_src);
        end
    end

    // A fresh edge is OR-ed in after clearing, so it survives both W1C and the ack clear.
    assign pend_clr  = ack_clr | (pend_we ? sr.sr_in[NSRC-1:0] : '0);
    assign pending_n = (pending & ~pend_clr) | (src_s & ~prev_src);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_out  <= 1'b0;
            cur_src  <= '0;
            prev_src <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            irq_out  <= irq_out_n;
            cur_src  <= cur_src_n;
            prev_src <= src_s;
            pending  <= pending_n;
            if (mask_we) begin
                mask <= sr.sr_in[NSRC-1:0];
            end
        end
    end

    always_comb begin
        sr.sr_out = '0;
        if (sr.sr_sel == 16'(SR_MASK)) begin
            sr.sr_out[NSRC-1:0] = mask;
        end else if (sr.sr_sel == 16'(SR_PEND)) begin
            sr.sr_out[NSRC-1:0] = pending;
        end else if (sr.sr_sel == 16'(SR_SRC)) begin
            sr.sr_out[3:0] = cur_src;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural model of the interrupt rules.
module tb_irq_ctrl;
    localparam int NSRC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_src = '0;
    logic       irq_en = 1'b0;
    logic       irq_ack = 1'b0;
    logic       irq_out;

    irq_ctrl_if bus ();

    irq_ctrl #(.NSRC(NSRC), .SR_MASK(5), .SR_PEND(6), .SR_SRC(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_src (irq_src),
        .irq_en  (irq_en),
        .irq_ack (irq_ack),
        .irq_out (irq_out),
        .sr      (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Behavioural model: phase 0 waiting, 1 requesting, 2 handler awaiting irq_en low, 3 awaiting irq_en high.
    int m_mask, m_pend, m_prev, m_s1, m_s2, m_cur, m_phase, m_out;

    task automatic model_reset();
        m_mask = 0; m_pend = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
        m_cur = 0; m_phase = 0; m_out = 0;
    endtask

    task automatic model_edge();
        int seen, rise, clr, act, found;
        int nphase, ncur, nout;
`ifdef IRQ_SYNC_EN
        seen = m_s2;
`else
        seen = int'(irq_src);
`endif
        rise = seen & ~m_prev & 'hFF;
        clr = 0;
        if (bus.sr_ie && bus.sr_sel == 16'd6) clr = int'(bus.sr_in) & 'hFF;
        nphase = m_phase; ncur = m_cur; nout = m_out;
        act = m_pend & m_mask;
        case (m_phase)
            0: if (irq_en && act != 0) begin
                found = -1;
                for (int b = 0; b < NSRC; b++)
                    if (found < 0 && ((act >> b) & 1) == 1) found = b;
                ncur = found; nout = 1; nphase = 1;
            end
            1: if (irq_ack) begin
                nout = 0; clr = clr | (1 << m_cur); nphase = 2;
            end
            2: if (!irq_en) nphase = 3;
            default: if (irq_en) nphase = 0;
        endcase
        m_pend = (m_pend & ~clr) | rise;
        if (bus.sr_ie && bus.sr_sel == 16'd5) m_mask = int'(bus.sr_in) & 'hFF;
        m_prev = seen;
        m_s2 = m_s1;
        m_s1 = int'(irq_src);
        m_phase = nphase; m_cur = ncur; m_out = nout;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] src, input logic ie, input logic [15:0] sel,
                         input logic [15:0] din, input logic en, input logic ack);
        irq_src = src; bus.sr_ie = ie; bus.sr_sel = sel; bus.sr_in = din;
        irq_en = en; irq_ack = ack;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [15:0] sel, output int v);
        bus.sr_ie = 1'b0;
        bus.sr_sel = sel;
        #1;
        v = int'(bus.sr_out);
    endtask

    task automatic check_dut(input string tag, input int e_out, input int e_pend,
                             input int e_mask, input int e_id);
        int v;
        chk({tag, ".irq_out"}, int'(irq_out), e_out);
        rd(16'd6, v); chk({tag, ".pending"}, v, e_pend);
        rd(16'd5, v); chk({tag, ".mask"}, v, e_mask);
        rd(16'd7, v); chk({tag, ".src_id"}, v, e_id);
    endtask

    task automatic wait_out(input string tag, input int budget);
        int n;
        n = 0;
        while (irq_out !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, ".irq_out_within_budget"}, int'(irq_out === 1'b1), 1);
    endtask

    typedef struct {
        logic [7:0]  src;
        logic        ie;
        logic [15:0] sel;
        logic [15:0] din;
        logic        en;
        logic        ack;
        int          out;
        int          pend;
        int          mask;
        int          id;
    } vec_t;

    vec_t tbl[25];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv;
        bus.sr_ie = 1'b0; bus.sr_sel = '0; bus.sr_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_dut("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

`ifndef IRQ_SYNC_EN
        //           src   ie    sel    din       en    ack   out pend  mask  id
        tbl[0]  = '{8'h00, 1'b1, 16'd5, 16'h0001, 1'b1, 1'b0, 0, 'h00, 'h01, 0};
        tbl[1]  = '{8'h01, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 0, 'h01, 'h01, 0};
        tbl[2]  = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1, 'h01, 'h01, 0};
        tbl[3]  = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1, 'h01, 'h01, 0};
        tbl[4]  = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b1, 0, 'h00, 'h01, 0};
        tbl[5]  = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 0, 'h00, 'h01, 0};
        tbl[6]  = '{8'h00, 1'b1, 16'd5, 16'h00FF, 1'b0, 1'b0, 0, 'h00, 'hFF, 0};
        tbl[7]  = '{8'h24, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0, 0, 'h24, 'hFF, 0};
        tbl[8]  = '{8'h24, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 0, 'h24, 'hFF, 0};
        tbl[9]  = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1, 'h24, 'hFF, 2};
        tbl[10] = '{8'h01, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1, 'h25, 'hFF, 2};
        tbl[11] = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b1, 0, 'h21, 'hFF, 2};
        tbl[12] = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0, 0, 'h21, 'hFF, 2};
        tbl[13] = '{8'h04, 1'b1, 16'd6, 16'h0004, 1'b0, 1'b0, 0, 'h25, 'hFF, 2};
        tbl[14] = '{8'h04, 1'b1, 16'd6, 16'h0021, 1'b0, 1'b0, 0, 'h04, 'hFF, 2};
        tbl[15] = '{8'h04, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 0, 'h04, 'hFF, 2};
        tbl[16] = '{8'h04, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1, 'h04, 'hFF, 2};
        tbl[17] = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b1, 0, 'h00, 'hFF, 2};
        tbl[18] = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0, 0, 'h00, 'hFF, 2};
        tbl[19] = '{8'h00, 1'b1, 16'd5, 16'h0000, 1'b1, 1'b0, 0, 'h00, 'h00, 2};
        tbl[20] = '{8'h08, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 0, 'h08, 'h00, 2};
        tbl[21] = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 0, 'h08, 'h00, 2};
        tbl[22] = '{8'h00, 1'b1, 16'd5, 16'h0008, 1'b1, 1'b0, 0, 'h08, 'h08, 2};
        tbl[23] = '{8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0, 1, 'h08, 'h08, 3};
        tbl[24] = '{8'h00, 1'b1, 16'd7, 16'hFFFF, 1'b1, 1'b1, 0, 'h00, 'h08, 3};
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].src, tbl[i].ie, tbl[i].sel, tbl[i].din, tbl[i].en, tbl[i].ack);
            step();
            check_dut($sformatf("row%0d", i), tbl[i].out, tbl[i].pend, tbl[i].mask, tbl[i].id);
        end
`else
        // Synchronized input: pending appears on the third edge that sees the line high.
        drive(8'h00, 1'b1, 16'd5, 16'h0001, 1'b1, 1'b0); step();
        drive(8'h01, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0); step();
        check_dut("sync_e1", 0, 'h00, 'h01, 0);
        step(); check_dut("sync_e2", 0, 'h00, 'h01, 0);
        step(); check_dut("sync_e3", 0, 'h01, 'h01, 0);
        step(); check_dut("sync_e4", 1, 'h01, 'h01, 0);
        drive(8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b1); step();
        check_dut("sync_ack", 0, 'h00, 'h01, 0);
`endif

        // SERVICE gating, then reset while a request is outstanding.
        rst_n = 1'b0; model_reset(); #2; rst_n = 1'b1;
        drive(8'h00, 1'b1, 16'd5, 16'h0002, 1'b1, 1'b0); step();
        drive(8'h02, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0); step();
        drive(8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0);
        wait_out("gate_first", 6);
        drive(8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b1); step();
        check_dut("gate_ack", 0, 'h00, 'h02, 1);
        drive(8'h00, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0); step();
        drive(8'h02, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0); step();
        drive(8'h00, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0);
        repeat (4) step();
        check_dut("gate_hold", 0, 'h02, 'h02, 1);
        drive(8'h00, 1'b0, 16'd0, 16'h0000, 1'b1, 1'b0);
        wait_out("gate_release", 2);
        check_dut("gate_req", 1, 'h02, 'h02, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_dut("reset_in_req", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] sel;
            case ($urandom_range(0, 3))
                0: sel = 16'd5;
                1: sel = 16'd6;
                2: sel = 16'd7;
                default: sel = 16'd2;
            endcase
            drive(irq_src ^ 8'($urandom & $urandom & $urandom),
                  ($urandom_range(0, 4) == 0), sel, 16'($urandom),
                  ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0));
            step();
            check_dut($sformatf("rand%0d", c), m_out, m_pend, m_mask, m_cur);
        end

        rd(16'd3, rv);
        chk("unlisted_select_reads_zero", rv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
